// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame geometry.
// The transmit block imports this package as well.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_rx_state_e;

  // Last counter value of the half-bit wait that centres sampling in the start bit.
  function automatic int unsigned half_bit_last(input int unsigned clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// Signal suffixes are named from the receiver's point of view.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_o;
  logic                      valid_o;
  logic                      ready_i;
  logic                      frame_err_o;
  logic                      overrun_o;
  logic                      busy_o;

  modport master (
    output data_o,
    output valid_o,
    input  ready_i,
    output frame_err_o,
    output overrun_o,
    output busy_o
  );

  modport slave (
    input  data_o,
    input  valid_o,
    output ready_i,
    input  frame_err_o,
    input  overrun_o,
    input  busy_o
  );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
// Both stages come out of reset at ResetVal so an idle line reads idle.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: synchronise, frame, mid-bit sample, and hand
// completed bytes over a single-entry valid/ready output register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_i,
  uart_receiver_if.master rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(half_bit_last(CLKS_PER_BIT));
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [2:0]      IdxLast = 3'(UART_DATA_BITS - 1);

  logic                      rx_sync;
  logic                      rx_prev_q;
  uart_rx_state_e            state_q;
  logic [CntW-1:0]           cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      start_edge;

  uart_sync2 #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx_i),
    .q_o    (rx_sync)
  );

  // Only a fresh 1->0 transition starts a frame; a line stuck low never does.
  assign start_edge = rx_prev_q & ~rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= rx_sync;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A byte completing in the same cycle overrides this clear below.
      if (valid_q && rx_if.ready_i) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end

        StStart: begin
          if (cnt_q == CntHalf) begin
            if (rx_sync) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync, shift_q[UART_DATA_BITS-1:1]};
            if (idx_q == IdxLast) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StStop: begin
          if (cnt_q == CntFull) begin
            state_q <= StIdle;
            if (!rx_sync) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || rx_if.ready_i) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_if.data_o      = data_q;
  assign rx_if.valid_o     = valid_q;
  assign rx_if.frame_err_o = frame_err_q;
  assign rx_if.overrun_o   = overrun_q;
  assign rx_if.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scenario tasks plus a randomized run
// compared against a frame-level reference model.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int Cpb = 8;
  localparam int Lat = 2 + 1 + Cpb / 2 + 9 * Cpb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i  = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx_i),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Observed-behaviour monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         cur_busy = 0;
  int         max_busy = 0;
  int         cur_valid = 0;
  int         max_valid = 0;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_if.valid_o && rx_if.ready_i) got_q.push_back(rx_if.data_o);
    if (rx_if.valid_o && !valid_prev) rise_q.push_back(cyc);
    valid_prev = rx_if.valid_o;
    if (rx_if.frame_err_o) fe_cnt++;
    if (rx_if.overrun_o) ov_cnt++;
    cur_busy = rx_if.busy_o ? cur_busy + 1 : 0;
    if (cur_busy > max_busy) max_busy = cur_busy;
    cur_valid = rx_if.valid_o ? cur_valid + 1 : 0;
    if (cur_valid > max_valid) max_valid = cur_valid;
  end

  task automatic clear_mon();
    got_q.delete();
    rise_q.delete();
    fe_cnt    = 0;
    ov_cnt    = 0;
    max_busy  = 0;
    max_valid = 0;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; every bit lasts exactly Cpb cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0   = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (rx_if.data_o !== 8'h00) begin n_err++;
      $display("FAIL reset data_o: got %h want 00", rx_if.data_o); end
    n_vec++; if (rx_if.valid_o !== 1'b0) begin n_err++;
      $display("FAIL reset valid_o: got %b want 0", rx_if.valid_o); end
    n_vec++; if (rx_if.frame_err_o !== 1'b0) begin n_err++;
      $display("FAIL reset frame_err_o: got %b want 0", rx_if.frame_err_o); end
    n_vec++; if (rx_if.overrun_o !== 1'b0) begin n_err++;
      $display("FAIL reset overrun_o: got %b want 0", rx_if.overrun_o); end
    n_vec++; if (rx_if.busy_o !== 1'b0) begin n_err++;
      $display("FAIL reset busy_o: got %b want 0", rx_if.busy_o); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int t0;
    int lat;
    clear_mon();
    send_frame(8'hA5, 1'b1, t0);
    idle(3 * Cpb);
    n_vec++; if (got_q.size() !== 1) begin n_err++;
      $display("FAIL basic count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== 8'hA5) begin n_err++;
        $display("FAIL basic data: got %h want a5", got_q[0]); end
    end
    if (rise_q.size() > 0) begin
      lat = rise_q[0] - t0;
      n_vec++; if (lat < Lat - 1 || lat > Lat + 1) begin n_err++;
        $display("FAIL basic latency: got %0d want %0d+-1", lat, Lat); end
    end
    n_vec++; if (max_valid !== 1) begin n_err++;
      $display("FAIL basic valid width: got %0d want 1", max_valid); end
    n_vec++; if (fe_cnt !== 0 || ov_cnt !== 0) begin n_err++;
      $display("FAIL basic flags: got fe=%0d ov=%0d want 0/0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(4 * Cpb);
    n_vec++; if (max_busy < 1 || max_busy > 6) begin n_err++;
      $display("FAIL glitch busy run: got %0d want 1..6", max_busy); end
    n_vec++; if (got_q.size() !== 0 || max_valid !== 0) begin n_err++;
      $display("FAIL glitch valid: got %0d bytes want 0", got_q.size()); end
    n_vec++; if (fe_cnt !== 0) begin n_err++;
      $display("FAIL glitch frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_mon();
    send_frame(8'h3C, 1'b0, t0);
    idle(2 * Cpb);
    n_vec++; if (fe_cnt !== 1) begin n_err++;
      $display("FAIL ferr pulses: got %0d want 1", fe_cnt); end
    n_vec++; if (max_valid !== 0) begin n_err++;
      $display("FAIL ferr valid: got %0d cycles want 0", max_valid); end
    clear_mon();
    send_frame(8'h81, 1'b1, t0);
    idle(2 * Cpb);
    n_vec++; if (got_q.size() !== 1) begin n_err++;
      $display("FAIL ferr recover count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== 8'h81) begin n_err++;
        $display("FAIL ferr recover data: got %h want 81", got_q[0]); end
    end
    n_vec++; if (fe_cnt !== 0) begin n_err++;
      $display("FAIL ferr recover flag: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_overrun();
    int t0;
    clear_mon();
    rx_if.ready_i = 1'b0;
    send_frame(8'h11, 1'b1, t0);
    send_frame(8'h22, 1'b1, t0);
    idle(2 * Cpb);
    n_vec++; if (rx_if.data_o !== 8'h11) begin n_err++;
      $display("FAIL overrun data: got %h want 11", rx_if.data_o); end
    n_vec++; if (rx_if.valid_o !== 1'b1) begin n_err++;
      $display("FAIL overrun valid: got %b want 1", rx_if.valid_o); end
    n_vec++; if (ov_cnt !== 1) begin n_err++;
      $display("FAIL overrun pulses: got %0d want 1", ov_cnt); end
    rx_if.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rx_if.valid_o !== 1'b0) begin n_err++;
      $display("FAIL overrun drain valid: got %b want 0", rx_if.valid_o); end
    n_vec++; if (got_q.size() !== 1) begin n_err++;
      $display("FAIL overrun drain count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat[3];
    int t0;
    int gap;
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h55;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1, t0);
    idle(2 * Cpb);
    n_vec++; if (got_q.size() !== 3) begin n_err++;
      $display("FAIL b2b count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) begin
        n_vec++; if (got_q[i] !== pat[i]) begin n_err++;
          $display("FAIL b2b data[%0d]: got %h want %h", i, got_q[i], pat[i]); end
      end
    end
    for (int i = 1; i < 3; i++) begin
      if (rise_q.size() > i) begin
        gap = rise_q[i] - rise_q[i-1];
        n_vec++; if (gap < 9 * Cpb || gap > 10 * Cpb) begin n_err++;
          $display("FAIL b2b spacing[%0d]: got %0d want %0d..%0d", i, gap, 9 * Cpb, 10 * Cpb);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    int t0;
    bits = {1'b1, 8'h7E, 1'b0};
    // Start bit and data bits 0..3, then part-way into bit 4.
    for (int i = 0; i < 5; i++) begin
      rx_i = bits[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    rx_i = bits[5];
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (rx_if.busy_o !== 1'b1) begin n_err++;
      $display("FAIL midrst busy before: got %b want 1", rx_if.busy_o); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (rx_if.data_o !== 8'h00 || rx_if.valid_o !== 1'b0) begin n_err++;
      $display("FAIL midrst data/valid: got %h/%b want 00/0", rx_if.data_o, rx_if.valid_o); end
    n_vec++; if (rx_if.busy_o !== 1'b0 || rx_if.frame_err_o !== 1'b0 ||
                 rx_if.overrun_o !== 1'b0) begin n_err++;
      $display("FAIL midrst flags: got busy=%b fe=%b ov=%b want 0", rx_if.busy_o,
               rx_if.frame_err_o, rx_if.overrun_o); end
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * Cpb);
    clear_mon();
    send_frame(8'h7E, 1'b1, t0);
    idle(2 * Cpb);
    n_vec++; if (got_q.size() !== 1) begin n_err++;
      $display("FAIL midrst fresh count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== 8'h7E) begin n_err++;
        $display("FAIL midrst fresh data: got %h want 7e", got_q[0]); end
    end
  endtask

  // Model: a frame with a high stop bit yields its byte in order; a low stop
  // bit yields exactly one framing error and no byte. Consumer always ready.
  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] b;
    logic       stop;
    int         t0;
    exp_fe = 0;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, t0);
      if (stop) exp_q.push_back(b);
      else exp_fe++;
      idle(stop ? $urandom_range(0, 12) : $urandom_range(2, 12));
    end
    idle(3 * Cpb);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++;
      $display("FAIL rand count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > i) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
          $display("FAIL rand data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_vec++; if (fe_cnt !== exp_fe) begin n_err++;
      $display("FAIL rand frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    n_vec++; if (ov_cnt !== 0) begin n_err++;
      $display("FAIL rand overrun: got %0d want 0", ov_cnt); end
  endtask

  initial begin
    rx_if.ready_i = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial receive front end for the SoC: turns the asynchronous `uart_rx` pad input (`ui_in[0]` at the chip top) into bytes for the SoC bus side.
- Synchronises the line, detects and validates 8N1 frames, samples each bit at mid-bit, and hands completed bytes downstream over a valid/ready handshake.
- Reports framing errors and overruns.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200). Legal range ≥ 4.

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low
- `rx_i`  input  1  raw serial line, idle high, asynchronous to `clk`
- `data_o`  output  8  received byte, LSB first on the wire
- `valid_o`  output  1  `data_o` holds an unconsumed byte
- `ready_i`  input  1  consumer accepts `data_o` when `valid_o && ready_i`
- `frame_err_o`  output  1  one-cycle pulse: stop bit sampled low
- `overrun_o`  output  1  one-cycle pulse: completed byte dropped because the output was still full
- `busy_o`  output  1  FSM not in IDLE

## Operation

- `rx_i` passes through a 2-flop synchroniser. Both flops reset to 1. A third flop, `rx_prev`, is used for edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised falling edge (`rx_prev`=1, `rx_sync`=0) clears the counter and moves to START. A line that is held low with no fresh edge does not start a frame.
  - START: the counter runs to `CLKS_PER_BIT/2 - 1` (integer divide), then the line is sampled.
    - Sample 1: false start. Return to IDLE; no flags.
    - Sample 0: clear the counter and the bit index, then go to DATA.
  - DATA: the counter runs to `CLKS_PER_BIT - 1`, then the line is sampled and shifted in at the MSB (right shift), so bit 0 lands in `data_o[0]`. After 8 samples, go to STOP.
  - STOP: the counter runs to `CLKS_PER_BIT - 1`, then the line is sampled and the FSM returns to IDLE.
    - Sample 1: byte completes.
    - Sample 0: pulse `frame_err_o`; the byte is discarded.
- Output register (single entry) on byte completion:
  - If `valid_o` = 0, or `ready_i` = 1 in the same cycle: load `data_o` and set `valid_o` = 1.
  - Otherwise pulse `overrun_o`, keep the old byte, and drop the new one.
- `valid_o && ready_i` with no completion in the same cycle clears `valid_o`.
- `data_o` holds its last value while `valid_o` = 0.
- Counter width is `$clog2(CLKS_PER_BIT)`; the counter never wraps past its terminal value. The bit index is 3 bits.
- Asserting reset mid-frame immediately returns the FSM to IDLE and discards partial data.

## Timing

- Reset values:
  - `data_o` = 8'h00
  - `valid_o`, `frame_err_o`, `overrun_o` = 0
  - `busy_o` = 0
  - synchroniser flops and `rx_prev` = 1
- Input latency: 2 cycles (synchroniser) plus 1 cycle (edge detect).
- `valid_o` rises on the clock edge after the stop-bit sample cycle.
- With no false start, that edge falls `2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the `rx_i` falling edge, ±1 cycle.
- `frame_err_o` and `overrun_o` are high for exactly one cycle, in the same cycle `valid_o` would have been updated.
- `busy_o` is combinational from the state register.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP. No dead time beyond the synchroniser.

## Structure

- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum (IDLE, START, DATA, STOP), 2-bit encoding.
  - `UART_DATA_BITS` = 8.
  - The TX block reuses this package.
- One sub-module, `uart_sync2`: a generic 2-flop synchroniser with a reset-value parameter. It is reused for other pad inputs.

## Test plan

Bench runs `CLKS_PER_BIT` = 8 with `ready_i` = 1 unless noted.

- Frame 0xA5, stop = 1 → `data_o` = 8'hA5, `valid_o` = 1 for one cycle, no error pulses.
- Low glitch of 3 cycles on idle line → back to IDLE; `busy_o` high for ≤ 6 cycles; no `valid_o`, no `frame_err_o`.
- Frame 0x3C with stop = 0, then line high → one `frame_err_o` pulse, `valid_o` stays 0. Next frame 0x81 → received correctly.
- `ready_i` = 0, two frames 0x11 then 0x22 → `data_o` stays 8'h11 and `overrun_o` pulses once. Raising `ready_i` clears `valid_o`.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three bytes in order, each `valid_o` exactly 9–10 bit times apart.
- `rst_n` asserted during DATA bit 4 → all outputs at reset values. A fresh frame 0x7E after release → 8'h7E.
